// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG user-chain memory bridge: opcodes, FSM states, status bits.
// Latency: none (declarations only).
// Backpressure: none.
package jtag_pkg;

  // Opcode field carried in the top two bits of every shifted-in frame
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_SETADDR = 2'b01,
    OP_WRITE   = 2'b10,
    OP_READ    = 2'b11
  } op_e;

  // Bridge sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WR     = 2'b01,
    RD     = 2'b10,
    RDWAIT = 2'b11
  } state_e;

  // Status bit positions in the captured word, as offsets above the read-data field
  localparam int STAT_BUSY = 0;
  localparam int STAT_OVR  = 1;
  localparam int STAT_ERR  = 2;

  // Width of the channel field: at least one bit even for a single channel
  function automatic int chan_w(input int nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

endpackage

// File: rtl/jtag_dr_shift.sv
// JTAG data register: parallel capture, LSB-first serial shift, TDO from bit 0.
// Latency: capture and shift take effect at the next rising clock edge.
// Backpressure: none; capture has priority over shift when both are requested.
module jtag_dr_shift #(
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap_en,
  input  logic         shift_en,
  input  logic         tdi,
  input  logic [L-1:0] cap_dat,
  output logic [L-1:0] sr_dat,
  output logic         tdo
);

  logic [L-1:0] sr_q;

  // Shift register: load status on capture, otherwise shift right with TDI entering at the top
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (cap_en) begin
      sr_q <= cap_dat;
    end else if (shift_en) begin
      sr_q <= {tdi, sr_q[L-1:1]};
    end
  end

  assign sr_dat = sr_q;
  assign tdo    = sr_q[0];

endmodule

// File: rtl/jtag_mem_bridge.sv
// JTAG user-chain to multi-channel memory bridge; optional JTAG_BRIDGE_AUTOINC_EN bumps the address after each access.
// Latency: access strobe one TCK after UPDATE; read data captured one cycle after the read strobe.
// Backpressure: an UPDATE arriving while an access is in flight is dropped and flagged in ovr_sticky.
module jtag_mem_bridge
  import jtag_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NCHAN  = 2,
  localparam int CW    = chan_w(NCHAN)
) (
  input  logic                    TCK,
  input  logic                    RESET_N,
  input  logic                    SEL,
  input  logic                    CAPTURE,
  input  logic                    SHIFT,
  input  logic                    UPDATE,
  input  logic                    TDI,
  output logic                    TDO,
  output logic                    MEM_EN,
  output logic                    MEM_WE,
  output logic [CW-1:0]           MEM_CH,
  output logic [ADDR_W-1:0]       MEM_ADDR,
  output logic [DATA_W-1:0]       MEM_WDATA,
  input  logic [NCHAN*DATA_W-1:0] MEM_RDATA,
  output logic                    BUSY
);

  localparam int L = 2 + CW + DATA_W;

`ifdef JTAG_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [CW-1:0]       ch_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q, ovr_q;
  logic [CW-1:0]       mem_ch_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic                cap_en, shift_en, upd_en;
  logic [L-1:0]        cap_dat, sr_dat;
  op_e                 f_op;
  logic [CW-1:0]       f_ch;
  logic [DATA_W-1:0]   f_pay;
  logic                ch_ok;
  logic                start, done, set_err, set_ovr;
  logic [DATA_W-1:0]   rd_sel;

  // TAP strobes only count while this chain is selected; a shift masks a simultaneous update
  assign cap_en   = SEL & CAPTURE;
  assign shift_en = SEL & SHIFT;
  assign upd_en   = SEL & UPDATE & ~SHIFT;

  assign f_op  = op_e'(sr_dat[L-1 -: 2]);
  assign f_ch  = sr_dat[DATA_W +: CW];
  assign f_pay = sr_dat[DATA_W-1:0];
  assign ch_ok = (32'(f_ch) < 32'(NCHAN));

  assign BUSY      = (state_q != IDLE);
  assign MEM_EN    = (state_q == WR) || (state_q == RD);
  assign MEM_WE    = (state_q == WR);
  assign MEM_CH    = mem_ch_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;

  // Status word presented to the shift register on capture
  always_comb begin
    cap_dat                     = '0;
    cap_dat[DATA_W-1:0]         = rdata_q;
    cap_dat[DATA_W + STAT_BUSY] = BUSY;
    cap_dat[DATA_W + STAT_OVR]  = ovr_q;
    cap_dat[DATA_W + STAT_ERR]  = err_q;
  end

  jtag_dr_shift #(.L(L)) u_dr (
    .clk      (TCK),
    .rst_n    (RESET_N),
    .cap_en   (cap_en),
    .shift_en (shift_en),
    .tdi      (TDI),
    .cap_dat  (cap_dat),
    .sr_dat   (sr_dat),
    .tdo      (TDO)
  );

  // Read-data mux over the channel held on the memory port
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (mem_ch_q == CW'(k)) rd_sel = MEM_RDATA[k*DATA_W +: DATA_W];
    end
  end

  // Sequencer: decode the frame on update in IDLE, then walk the one-cycle access states
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    set_err = 1'b0;
    set_ovr = 1'b0;
    case (state_q)
      IDLE: begin
        if (upd_en && (f_op == OP_WRITE || f_op == OP_READ)) begin
          if (ch_ok) begin
            state_d = (f_op == OP_WRITE) ? WR : RD;
            start   = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      WR: begin
        state_d = IDLE;
        done    = 1'b1;
      end
      RD: state_d = RDWAIT;
      RDWAIT: begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (upd_en && state_q != IDLE) set_ovr = 1'b1;
  end

  // State register
  always_ff @(posedge TCK) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Address, memory port, read data and sticky status registers
  always_ff @(posedge TCK) begin
    if (!RESET_N) begin
      addr_q      <= '0;
      ch_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      mem_ch_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (upd_en && state_q == IDLE && f_op == OP_SETADDR) begin
        addr_q <= f_pay[ADDR_W-1:0];
        ch_q   <= f_ch;
      end else if (AUTOINC && done) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      // Port is loaded when an access starts and otherwise parks on the programmed target,
      // so it never moves while MEM_EN is high
      if (start) begin
        mem_ch_q    <= f_ch;
        mem_addr_q  <= addr_q;
        mem_wdata_q <= f_pay;
      end else if (state_q == IDLE) begin
        mem_ch_q   <= ch_q;
        mem_addr_q <= addr_q;
      end
      if (state_q == RDWAIT) rdata_q <= rd_sel;
      // Capture clears the flags, but an event in the same cycle wins
      err_q <= (err_q & ~cap_en) | set_err;
      ovr_q <= (ovr_q & ~cap_en) | set_ovr;
    end
  end

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Self-checking bench for jtag_mem_bridge: directed vector table, hand-written corner sequences, random traffic.
// Latency: checks access strobes one TCK after UPDATE and read data one cycle after the read strobe.
// Backpressure: exercises UPDATE while a read is in flight and reset in the read-wait state.
module tb_jtag_mem_bridge;

  // Three channels so that the 2-bit channel field can name an absent channel (3)
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int NCHAN  = 3;
  localparam int CW     = 2;
  localparam int L      = 2 + CW + DATA_W;
`ifdef JTAG_BRIDGE_AUTOINC_EN
  localparam int AI = 1;
`else
  localparam int AI = 0;
`endif

  logic                    TCK = 1'b0;
  logic                    RESET_N, SEL, CAPTURE, SHIFT, UPDATE, TDI;
  logic                    TDO, MEM_EN, MEM_WE, BUSY;
  logic [CW-1:0]           MEM_CH;
  logic [ADDR_W-1:0]       MEM_ADDR;
  logic [DATA_W-1:0]       MEM_WDATA;
  logic [NCHAN*DATA_W-1:0] MEM_RDATA;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic              we;
    logic [CW-1:0]     ch;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;
  acc_t acc_q[$];

  // Reference model state
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_rdata;
  bit                m_err, m_ovr;
  bit                ch0_fix;

  always #5 TCK = ~TCK;

  jtag_mem_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCHAN(NCHAN)) dut (
    .TCK(TCK), .RESET_N(RESET_N), .SEL(SEL), .CAPTURE(CAPTURE), .SHIFT(SHIFT),
    .UPDATE(UPDATE), .TDI(TDI), .TDO(TDO), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE),
    .MEM_CH(MEM_CH), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
  );

  // Memory contents: a fixed function of channel and address
  function automatic logic [DATA_W-1:0] mem_word(input int k, input logic [ADDR_W-1:0] a);
    if (k == 0 && ch0_fix) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ (32'(k + 1) * 32'h01010101);
  endfunction

  // Every cycle with MEM_EN high is one recorded access
  initial forever begin
    @(negedge TCK);
    if (MEM_EN) acc_q.push_back('{MEM_WE, MEM_CH, MEM_ADDR, MEM_WDATA});
  end

  // Read responder with latency one: data valid only in the cycle after the strobe, junk otherwise
  initial begin
    bit pend;
    logic [ADDR_W-1:0] pa;
    MEM_RDATA = '0;
    forever begin
      @(negedge TCK);
      pend = MEM_EN && !MEM_WE;
      pa   = MEM_ADDR;
      @(posedge TCK);
      #2;
      for (int k = 0; k < NCHAN; k++)
        MEM_RDATA[k*DATA_W +: DATA_W] = pend ? mem_word(k, pa) : DATA_W'($urandom);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge TCK);
    #1;
  endtask

  task automatic model_reset();
    m_addr = '0; m_rdata = '0; m_err = 0; m_ovr = 0;
  endtask

  // Shift a frame in LSB first while collecting what comes out on TDO
  task automatic scan(input logic [L-1:0] din, output logic [L-1:0] dout);
    SEL = 1; SHIFT = 1;
    for (int i = 0; i < L; i++) begin
      TDI = din[i];
      dout[i] = TDO;
      step();
    end
    SHIFT = 0; TDI = 0;
  endtask

  task automatic read_status(output logic [L-1:0] st, output logic [L-1:0] ex);
    ex = {1'b0, m_err, m_ovr, 1'b0, m_rdata};
    SEL = 1; CAPTURE = 1;
    step();
    CAPTURE = 0;
    scan('0, st);
    m_err = 0; m_ovr = 0;
  endtask

  task automatic send(input logic [1:0] op, input logic [CW-1:0] ch,
                      input logic [DATA_W-1:0] pay, output bit busy1);
    logic [L-1:0] d;
    scan({op, ch, pay}, d);
    UPDATE = 1;
    step();
    UPDATE = 0;
    busy1 = BUSY;
    repeat (4) step();
  endtask

  // Model: what a frame should do to the address, flags and memory port
  task automatic model(input logic [1:0] op, input logic [CW-1:0] ch, input logic [DATA_W-1:0] pay,
                       output bit ea, output acc_t ex);
    ea = 0;
    ex = '{1'b0, '0, '0, '0};
    if (op == 2'd1) begin
      m_addr = pay[ADDR_W-1:0];
    end else if (op >= 2'd2) begin
      if (int'(ch) >= NCHAN) begin
        m_err = 1;
      end else begin
        ea = 1;
        ex = '{op == 2'd2, ch, m_addr, pay};
        if (op == 2'd3) m_rdata = mem_word(int'(ch), m_addr);
        m_addr = m_addr + ADDR_W'(AI);
      end
    end
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [CW-1:0] ch,
                     input logic [DATA_W-1:0] pay, output acc_t got);
    bit ea, b;
    acc_t ex;
    model(op, ch, pay, ea, ex);
    send(op, ch, pay, b);
    got = '{1'b0, '0, '0, '0};
    check({name, " busy"}, 64'(b), 64'(ea));
    check({name, " n_acc"}, 64'(acc_q.size()), 64'(ea));
    if (acc_q.size() > 0) begin
      got = acc_q.pop_front();
      if (ea) begin
        check({name, " we"}, 64'(got.we), 64'(ex.we));
        check({name, " ch"}, 64'(got.ch), 64'(ex.ch));
        check({name, " addr"}, 64'(got.addr), 64'(ex.addr));
        if (ex.we) check({name, " wdata"}, 64'(got.wdata), 64'(ex.wdata));
      end
    end
    acc_q.delete();
    check({name, " idle"}, 64'(BUSY), 64'(0));
  endtask

  typedef struct {
    logic [1:0]        op;
    logic [CW-1:0]     ch;
    logic [DATA_W-1:0] pay;
    bit                acc;
    logic              we;
    logic [CW-1:0]     ech;
    logic [ADDR_W-1:0] eaddr;
    logic [DATA_W-1:0] ewd;
    bit                eerr;
  } vec_t;

  initial begin
    vec_t tbl[9];
    logic [L-1:0] st, ex, d;
    acc_t g, e;
    bit ea, b;

    tbl[0] = '{2'd1, 2'd1, 32'h00000010, 0, 1'b0, 2'd0, 32'h0,        32'h0,        0};
    tbl[1] = '{2'd2, 2'd1, 32'hDEADBEEF, 1, 1'b1, 2'd1, 32'h10,       32'hDEADBEEF, 0};
    tbl[2] = '{2'd2, 2'd3, 32'h0BADF00D, 0, 1'b0, 2'd0, 32'h0,        32'h0,        1};
    tbl[3] = '{2'd0, 2'd0, 32'h00000000, 0, 1'b0, 2'd0, 32'h0,        32'h0,        0};
    tbl[4] = '{2'd1, 2'd0, 32'h00000200, 0, 1'b0, 2'd0, 32'h0,        32'h0,        0};
    tbl[5] = '{2'd2, 2'd2, 32'h5555AAAA, 1, 1'b1, 2'd2, 32'h200,      32'h5555AAAA, 0};
    tbl[6] = '{2'd2, 2'd0, 32'h00000001, 1, 1'b1, 2'd0, 32'h200 + AI, 32'h1,        0};
    tbl[7] = '{2'd3, 2'd3, 32'h00000000, 0, 1'b0, 2'd0, 32'h0,        32'h0,        1};
    tbl[8] = '{2'd3, 2'd1, 32'h00000000, 1, 1'b0, 2'd1, 32'h200+2*AI, 32'h0,        0};

    RESET_N = 0; SEL = 0; CAPTURE = 0; SHIFT = 0; UPDATE = 0; TDI = 0;
    ch0_fix = 0;
    model_reset();
    step(); step();
    check("rst TDO", 64'(TDO), 0);
    check("rst MEM_EN", 64'(MEM_EN), 0);
    check("rst MEM_WE", 64'(MEM_WE), 0);
    check("rst MEM_ADDR", 64'(MEM_ADDR), 0);
    check("rst BUSY", 64'(BUSY), 0);
    RESET_N = 1;
    step();
    read_status(st, ex);
    check("rst status", 64'(st), 64'(0));
    acc_q.delete();

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      model(tbl[i].op, tbl[i].ch, tbl[i].pay, ea, e);
      send(tbl[i].op, tbl[i].ch, tbl[i].pay, b);
      check($sformatf("vec%0d n_acc", i), 64'(acc_q.size()), 64'(tbl[i].acc));
      check($sformatf("vec%0d busy", i), 64'(b), 64'(tbl[i].acc));
      if (tbl[i].acc && acc_q.size() > 0) begin
        g = acc_q.pop_front();
        check($sformatf("vec%0d we", i), 64'(g.we), 64'(tbl[i].we));
        check($sformatf("vec%0d ch", i), 64'(g.ch), 64'(tbl[i].ech));
        check($sformatf("vec%0d addr", i), 64'(g.addr), 64'(tbl[i].eaddr));
        if (tbl[i].we) check($sformatf("vec%0d wdata", i), 64'(g.wdata), 64'(tbl[i].ewd));
      end
      acc_q.delete();
      read_status(st, ex);
      check($sformatf("vec%0d err", i), 64'(st[DATA_W+2]), 64'(tbl[i].eerr));
    end

    // Read of channel 0 returning a fixed word
    ch0_fix = 1;
    run("rd0 setaddr", 2'd1, 2'd0, 32'h00000040, g);
    run("rd0 read", 2'd3, 2'd0, 32'h0, g);
    read_status(st, ex);
    check("rd0 payload", 64'(st[DATA_W-1:0]), 64'h12345678);
    check("rd0 busy bit", 64'(st[DATA_W]), 0);
    ch0_fix = 0;

    // Address wrap across two writes
    run("wrap setaddr", 2'd1, 2'd0, 32'hFFFFFFFF, g);
    run("wrap wr1", 2'd2, 2'd1, 32'hA1A1A1A1, g);
    check("wrap addr1", 64'(g.addr), 64'hFFFFFFFF);
    run("wrap wr2", 2'd2, 2'd1, 32'hB2B2B2B2, g);
    check("wrap addr2", 64'(g.addr), (AI != 0) ? 64'h0 : 64'hFFFFFFFF);

    // UPDATE while the read strobe is out: frame dropped, overrun flagged
    run("ovr setaddr", 2'd1, 2'd0, 32'h00000030, g);
    model(2'd3, 2'd2, 32'h0, ea, e);
    scan({2'd3, 2'd2, 32'h0}, d);
    UPDATE = 1;
    step();
    check("ovr rd strobe", 64'({MEM_EN, MEM_WE, BUSY}), 64'b101);
    step();
    UPDATE = 0;
    m_ovr = 1;
    repeat (4) step();
    check("ovr n_acc", 64'(acc_q.size()), 1);
    if (acc_q.size() > 0) begin
      g = acc_q.pop_front();
      check("ovr addr", 64'(g.addr), 64'(e.addr));
    end
    acc_q.delete();
    read_status(st, ex);
    check("ovr status", 64'(st), 64'(ex));
    read_status(st, ex);
    check("ovr cleared", 64'(st), 64'(ex));

    // Reset in RDWAIT aborts the read and clears every output
    scan({2'd3, 2'd1, 32'h00000001}, d);
    UPDATE = 1;
    step();
    UPDATE = 0;
    step();
    check("abort rdwait busy", 64'(BUSY), 1);
    RESET_N = 0;
    step();
    check("abort outs", 64'({TDO, MEM_EN, MEM_WE, BUSY, MEM_CH, MEM_ADDR, MEM_WDATA}), 64'(0));
    RESET_N = 1;
    model_reset();
    acc_q.delete();
    repeat (4) step();
    check("abort no pulse", 64'(acc_q.size()), 0);
    read_status(st, ex);
    check("abort status", 64'(st), 64'(0));

    // Strobes ignored without SEL; SHIFT masks UPDATE
    scan({2'd2, 2'd0, 32'hCAFEF00D}, d);
    SEL = 0; UPDATE = 1;
    step();
    UPDATE = 0; SEL = 1;
    repeat (3) step();
    check("nosel n_acc", 64'(acc_q.size()), 0);
    SHIFT = 1; UPDATE = 1;
    step();
    SHIFT = 0; UPDATE = 0;
    repeat (3) step();
    check("shupd n_acc", 64'(acc_q.size()), 0);
    acc_q.delete();
    read_status(st, ex);
    check("nosel status", 64'(st), 64'(ex));

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      logic [1:0]        op;
      logic [CW-1:0]     ch;
      logic [DATA_W-1:0] pay;
      op  = 2'($urandom_range(0, 3));
      ch  = CW'($urandom_range(0, 3));
      pay = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 1)) : 32'($urandom);
      run($sformatf("rnd%0d", i), op, ch, pay, g);
      if ($urandom_range(0, 2) == 0 || op == 2'd3) begin
        read_status(st, ex);
        check($sformatf("rnd%0d status", i), 64'(st), 64'(ex));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
